// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
package pc_pkg;

   typedef enum logic [2:0] {
      PC_SEL_TRAP,
      PC_SEL_HOLD,
      PC_SEL_RET,
      PC_SEL_REDIRECT,
      PC_SEL_SEQ
   } pc_sel_e;

   localparam int unsigned STEP_MIN      = 1;
   localparam int unsigned RAS_DEPTH_MIN = 2;

   // Legal STEP / RAS_DEPTH values are nonzero powers of two above their minimum.
   function automatic bit is_legal_pow2(input int unsigned v, input int unsigned min_v);
      return (v >= min_v) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module return_stack
   import pc_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_push_data,
   output logic [WIDTH-1:0] o_top_c,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_overflow,
   output logic             o_underflow
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   logic [WIDTH-1:0] r_mem [RAS_DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_ptr_nxt;
   logic [PTR_W-1:0] w_top_idx;
   logic [PTR_W-1:0] w_wr_idx;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_wr_en;
   logic             w_is_empty;
   logic             w_is_full;
   logic             r_empty;
   logic             r_full;
   logic             r_overflow;
   logic             r_underflow;

   assign w_is_empty = (r_cnt == '0);
   assign w_is_full  = (r_cnt == CNT_W'(RAS_DEPTH));
   assign w_top_idx  = r_ptr - PTR_W'(1);
   assign o_top_c    = r_mem[w_top_idx];

   // Pointer names the next free slot; push+pop on a non-empty stack rewrites the top in place.
   always_comb begin
      w_ptr_nxt = r_ptr;
      w_cnt_nxt = r_cnt;
      w_wr_en   = 1'b0;
      w_wr_idx  = r_ptr;
      if (i_flush) begin
         w_ptr_nxt = '0;
         w_cnt_nxt = '0;
      end else if (i_push && i_pop) begin
         w_wr_en = 1'b1;
         if (w_is_empty) begin
            w_ptr_nxt = r_ptr + PTR_W'(1);
            w_cnt_nxt = CNT_W'(1);
         end else begin
            w_wr_idx = w_top_idx;
         end
      end else if (i_push) begin
         w_wr_en   = 1'b1;
         w_ptr_nxt = r_ptr + PTR_W'(1);
         if (!w_is_full) w_cnt_nxt = r_cnt + CNT_W'(1);
      end else if (i_pop && !w_is_empty) begin
         w_ptr_nxt = w_top_idx;
         w_cnt_nxt = r_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_empty     <= 1'b1;
         r_full      <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_ptr       <= w_ptr_nxt;
         r_cnt       <= w_cnt_nxt;
         r_empty     <= (w_cnt_nxt == '0);
         r_full      <= (w_cnt_nxt == CNT_W'(RAS_DEPTH));
         r_overflow  <= !i_flush && i_push && !i_pop && w_is_full;
         r_underflow <= !i_flush && i_pop && w_is_empty;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[w_wr_idx] <= i_push_data;
   end

   assign o_empty     = r_empty;
   assign o_full      = r_full;
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: prioritised trap/return/redirect mux, stall gating,
// return-address prediction and misaligned-target detection.
module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
   parameter int unsigned      STEP         = 4,
   parameter int unsigned      RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_pc_write,
   input  logic             i_trap_valid,
   input  logic             i_redirect_valid,
   input  logic [WIDTH-1:0] i_redirect_target,
   input  logic             i_call_valid,
   input  logic             i_ret_valid,
   output logic [WIDTH-1:0] o_pc,
   output logic             o_ras_empty,
   output logic             o_ras_full,
   output logic             o_ras_underflow,
   output logic             o_ras_overflow,
   output logic             o_misalign_err
);

   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] w_pc_seq;
   logic [WIDTH-1:0] w_tgt_aligned;
   logic [WIDTH-1:0] w_ras_top;
   logic             w_tgt_misaligned;
   logic             w_misalign_nxt;
   logic             r_misalign;
   logic             w_active;
   logic             w_push;
   logic             w_pop;
   logic             w_ras_empty;
   pc_sel_e          w_sel;

   assign w_pc_seq         = r_pc + WIDTH'(STEP);
   assign w_tgt_aligned    = i_redirect_target & ~ALIGN_MASK;
   assign w_tgt_misaligned = |(i_redirect_target & ALIGN_MASK);

   // A trap or a stall suppresses every stack operation.
   assign w_active = i_pc_write && !i_trap_valid;
   assign w_pop    = w_active && i_ret_valid;
   assign w_push   = w_active && i_call_valid && (i_redirect_valid || i_ret_valid);

   always_comb begin
      w_sel = PC_SEL_SEQ;
      if (i_trap_valid)          w_sel = PC_SEL_TRAP;
      else if (!i_pc_write)      w_sel = PC_SEL_HOLD;
      else if (i_ret_valid)      w_sel = PC_SEL_RET;
      else if (i_redirect_valid) w_sel = PC_SEL_REDIRECT;
   end

   always_comb begin
      w_pc_nxt       = r_pc;
      w_misalign_nxt = 1'b0;
      case (w_sel)
         PC_SEL_TRAP: w_pc_nxt = TRAP_VECTOR;
         PC_SEL_HOLD: w_pc_nxt = r_pc;
         PC_SEL_RET: begin
            if (w_ras_empty) begin
               w_pc_nxt       = w_tgt_aligned;
               w_misalign_nxt = w_tgt_misaligned;
            end else begin
               w_pc_nxt = w_ras_top;
            end
         end
         PC_SEL_REDIRECT: begin
            w_pc_nxt       = w_tgt_aligned;
            w_misalign_nxt = w_tgt_misaligned;
         end
         default: w_pc_nxt = w_pc_seq;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= RESET_VECTOR;
         r_misalign <= 1'b0;
      end else begin
         r_pc       <= w_pc_nxt;
         r_misalign <= w_misalign_nxt;
      end
   end

   return_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_flush     (i_trap_valid),
      .i_push_data (w_pc_seq),
      .o_top_c     (w_ras_top),
      .o_empty     (w_ras_empty),
      .o_full      (o_ras_full),
      .o_overflow  (o_ras_overflow),
      .o_underflow (o_ras_underflow)
   );

   assign o_pc           = r_pc;
   assign o_ras_empty    = w_ras_empty;
   assign o_misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// Randomised and directed check of pc_gen against a queue-based behavioural model.
module tb_pc_gen;

   localparam int unsigned     W     = 32;
   localparam int unsigned     DEPTH = 4;
   localparam logic [W-1:0]    RV    = 32'h0000_1000;
   localparam logic [W-1:0]    TV    = 32'h0000_0100;

   logic         clk = 1'b0;
   logic         rst;
   logic         pc_write, trap_valid, redirect_valid, call_valid, ret_valid;
   logic [W-1:0] redirect_target;
   logic [W-1:0] pc;
   logic         ras_empty, ras_full, ras_underflow, ras_overflow, misalign_err;

   int unsigned  n_cmp = 0;
   int unsigned  n_err = 0;

   logic [W-1:0] m_pc;
   logic [W-1:0] m_q [$];
   logic         m_und, m_ovf, m_mis;

   always #5 clk = ~clk;

   pc_gen #(
      .WIDTH        (W),
      .RESET_VECTOR (RV),
      .TRAP_VECTOR  (TV),
      .STEP         (4),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .i_pc_write        (pc_write),
      .i_trap_valid      (trap_valid),
      .i_redirect_valid  (redirect_valid),
      .i_redirect_target (redirect_target),
      .i_call_valid      (call_valid),
      .i_ret_valid       (ret_valid),
      .o_pc              (pc),
      .o_ras_empty       (ras_empty),
      .o_ras_full        (ras_full),
      .o_ras_underflow   (ras_underflow),
      .o_ras_overflow    (ras_overflow),
      .o_misalign_err    (misalign_err)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check("pc", pc, m_pc);
      check("ras_empty", W'(ras_empty), W'(m_q.size() == 0));
      check("ras_full", W'(ras_full), W'(m_q.size() == DEPTH));
      check("ras_underflow", W'(ras_underflow), W'(m_und));
      check("ras_overflow", W'(ras_overflow), W'(m_ovf));
      check("misalign_err", W'(misalign_err), W'(m_mis));
   endtask

   task automatic model_reset();
      m_pc = RV;
      m_q.delete();
      m_und = 1'b0;
      m_ovf = 1'b0;
      m_mis = 1'b0;
   endtask

   // Next state from the priority rules: trap, stall, return, redirect, sequential.
   task automatic model_step(input bit pw, input bit tr, input bit rv, input logic [W-1:0] tgt,
                             input bit cl, input bit rt);
      logic [W-1:0] ret_addr;
      logic [W-1:0] aligned;
      ret_addr = m_pc + 32'd4;
      aligned  = {tgt[W-1:2], 2'b00};
      m_und = 1'b0;
      m_ovf = 1'b0;
      m_mis = 1'b0;
      if (tr) begin
         m_pc = TV;
         m_q.delete();
      end else if (pw) begin
         if (rt) begin
            if (m_q.size() > 0) begin
               m_pc = m_q.pop_back();
            end else begin
               m_pc  = aligned;
               m_und = 1'b1;
               m_mis = (tgt[1:0] != 2'b00);
            end
            if (cl) m_q.push_back(ret_addr);
         end else if (rv) begin
            m_pc  = aligned;
            m_mis = (tgt[1:0] != 2'b00);
            if (cl) begin
               if (m_q.size() == DEPTH) begin
                  void'(m_q.pop_front());
                  m_ovf = 1'b1;
               end
               m_q.push_back(ret_addr);
            end
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic cycle(input bit pw, input bit tr, input bit rv, input logic [W-1:0] tgt,
                        input bit cl, input bit rt);
      pc_write        = pw;
      trap_valid      = tr;
      redirect_valid  = rv;
      redirect_target = tgt;
      call_valid      = cl;
      ret_valid       = rt;
      @(posedge clk);
      model_step(pw, tr, rv, tgt, cl, rt);
      #1;
      check_all();
   endtask

   initial begin
      logic [W-1:0] tgt;
      rst = 1'b1;
      pc_write = 1'b0; trap_valid = 1'b0; redirect_valid = 1'b0;
      call_valid = 1'b0; ret_valid = 1'b0; redirect_target = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all();

      // Sequential fetch from the reset vector.
      repeat (3) cycle(1, 0, 0, 32'h0, 0, 0);
      check("seq_100c", pc, 32'h0000_100C);

      // Call then return two cycles later.
      cycle(1, 0, 1, 32'h2000, 0, 0);
      cycle(1, 0, 1, 32'h3000, 1, 0);
      cycle(1, 0, 0, 32'h0, 0, 0);
      cycle(1, 0, 0, 32'hDEAD_0000, 0, 1);
      check("ret_2004", pc, 32'h0000_2004);

      // Five nested calls overflow a 4-deep stack; fifth return underflows.
      for (int i = 0; i < 5; i++) cycle(1, 0, 1, 32'h6000 + 32'(i) * 32'h100, 1, 0);
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 32'h7000, 0, 1);
      check("underflow_pc", pc, 32'h0000_7000);

      // Stall holds through a redirect; trap still acts while stalled.
      cycle(1, 0, 1, 32'h1010, 0, 0);
      cycle(0, 0, 1, 32'h4000, 0, 0);
      check("stall_hold", pc, 32'h0000_1010);
      cycle(0, 1, 0, 32'h0, 0, 0);
      check("trap_stall", pc, TV);

      // Misaligned target and wrap at the top of the address space.
      cycle(1, 0, 1, 32'h5002, 0, 0);
      cycle(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
      cycle(1, 0, 0, 32'h0, 0, 0);
      check("wrap_zero", pc, 32'h0);

      // Asynchronous reset in the middle of a call sequence.
      cycle(1, 0, 1, 32'h8000, 1, 0);
      cycle(1, 0, 1, 32'h9000, 1, 0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #2 rst = 1'b0;
      cycle(1, 0, 0, 32'h0, 0, 0);

      // Randomised traffic.
      for (int n = 0; n < 3000; n++) begin
         tgt = $urandom;
         if (($urandom % 8) != 0) tgt = tgt & 32'h0000_FFFF;
         if (($urandom % 4) != 0) tgt[1:0] = 2'b00;
         cycle(($urandom % 8) != 0, ($urandom % 50) == 0, ($urandom % 3) == 0, tgt,
               ($urandom % 3) == 0, ($urandom % 5) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It supersedes the plain write-enabled PC register and adds:
- sequential increment;
- prioritised redirect (trap, return, branch/jump/call);
- stall gating;
- a circular return-address stack (RAS) for call/return prediction;
- misaligned-target detection.

It sits between decode/execute redirect logic and the instruction-memory address port.

## Interface
Parameters:
- WIDTH, 32, PC and address width in bits
- RESET_VECTOR, 0, PC value after reset
- TRAP_VECTOR, 32'h0000_0100 (WIDTH bits), PC loaded on trap
- STEP, 4, sequential increment in bytes; power of 2, ≥ 1
- RAS_DEPTH, 4, return-stack entries; power of 2, ≥ 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pc_write  in  1  1 = PC may advance; 0 = stall
- trap_valid  in  1  exception/interrupt redirect
- redirect_valid  in  1  branch/jump/call taken
- redirect_target  in  WIDTH  target for redirect; fallback target for return on empty RAS
- call_valid  in  1  current redirect is a call; push pc+STEP
- ret_valid  in  1  return; pop RAS
- pc  out  WIDTH  current fetch address
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_underflow  out  1  one-cycle pulse: return with empty RAS
- ras_overflow  out  1  one-cycle pulse: call overwrote the oldest entry
- misalign_err  out  1  one-cycle pulse: redirect target not STEP-aligned

## Operation
- Next-PC priority, evaluated every cycle:
  1. trap_valid: pc ← TRAP_VECTOR; RAS flushed (count 0, pointer 0). Acts even when pc_write=0.
  2. pc_write=0: pc holds; no RAS push/pop; pulses stay 0. redirect/call/ret inputs are ignored; upstream holds them until pc_write=1.
  3. ret_valid: pc ← RAS top, pop (count−1). If RAS empty: pc ← aligned redirect_target, ras_underflow=1, count stays 0.
  4. redirect_valid: pc ← aligned redirect_target.
  5. Otherwise: pc ← pc + STEP, modulo 2^WIDTH (wraps silently at all-ones).
- Push: call_valid with redirect_valid pushes pc+STEP (old pc, modulo 2^WIDTH).
  - RAS full: write at the circular pointer, overwriting the oldest entry; count stays RAS_DEPTH; ras_overflow=1.
- call_valid without redirect_valid or ret_valid: ignored.
- call_valid and ret_valid together (tail call through return):
  - pc ← popped top, or fallback target if empty;
  - top slot is then overwritten with old pc+STEP;
  - net count unchanged (empty case: becomes 1, ras_underflow=1).
- Alignment: target low log2(STEP) bits nonzero → those bits are cleared before loading, and misalign_err=1. Popped RAS values are always aligned (pushed values are pc+STEP). TRAP_VECTOR must be aligned; this is not checked.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH).

## Timing
- Reset values (asynchronous, immediate):
  - pc = RESET_VECTOR;
  - RAS count 0, pointer 0; entry contents don't-care;
  - ras_empty=1, ras_full=0, all pulses 0.
- Latency: all outputs registered. Inputs sampled at edge N take effect in pc and flags after edge N. One redirect per cycle, zero bubble.
- Pulses are high for exactly the cycle following the triggering edge. They are cleared on any cycle without a new event.
- Reset asserted mid-operation aborts any pending push/pop; first post-reset fetch address is RESET_VECTOR.
- Stall across a redirect: redirect_valid with pc_write=0 has no effect. The same redirect presented later with pc_write=1 takes effect normally.

## Structure
- Shared package pc_pkg:
  - next-PC select enum PC_SEL_TRAP, PC_SEL_HOLD, PC_SEL_RET, PC_SEL_REDIRECT, PC_SEL_SEQ;
  - STEP/RAS_DEPTH legality helper constants.
- Sub-module return_stack (WIDTH, RAS_DEPTH):
  - circular storage, pointer, saturating count;
  - push/pop/flush inputs; top, empty, full, overflow, underflow outputs.
- pc_gen holds the PC register, priority mux and alignment logic.

## Test plan
- Reset with RESET_VECTOR=32'h1000, pc_write=1, no redirects, 3 cycles → pc = 1000, 1004, 1008, 100C; ras_empty=1.
- At pc=2000: call to 3000 (redirect+call), then ret 2 cycles later → pc=3000, 3004, then 2004; count 1→0.
- RAS_DEPTH=4: 5 nested calls → ras_overflow pulse on 5th; 4 rets return 5th..2nd return addresses; 5th ret → ras_underflow and pc=redirect_target.
- pc_write=0 with redirect_valid to 4000 and pc=1010 → pc holds 1010. Then trap_valid while pc_write=0 → pc=TRAP_VECTOR, ras_empty=1.
- Redirect to 32'h5002 with STEP=4 → pc=5000, misalign_err one-cycle pulse.
- pc=32'hFFFF_FFFC, sequential → pc=0. Reset asserted mid call/ret sequence → pc=RESET_VECTOR, ras_empty=1 asynchronously.
